// File: rtl/dmem_arbiter.sv
// Arbitrates the single data memory between the core memory stage and an external
// requester; the core has priority, with a starvation counter forcing an external grant.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_core_rd_en,
  input  logic                       in_core_wr_en,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_core_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_core_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_core_wr_word,
  output logic                       out_core_stall,
  input  logic                       in_ext_req,
  input  logic                       in_ext_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_ext_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_ext_wdata,
  output logic                       out_ext_gnt,
  output logic                       out_ext_rvalid,
  output logic [DMEM_WORD_WIDTH-1:0] out_ext_rdata,
  input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
  output logic                       out_mem_write_en
);

  // A limit of 0 would give a zero-width counter, so keep at least one bit.
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    IDLE  = 1'b0,
    FORCE = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_next, starve_cnt_inc;
  logic             core_active, blocked, rvalid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
      rvalid_q   <= out_ext_gnt & ~in_ext_we;
    end
  end

  always_comb begin
    core_active     = in_core_rd_en | in_core_wr_en;
    out_ext_gnt     = reset & in_ext_req & (~core_active | (state == FORCE));
    out_core_stall  = reset & (state == FORCE) & in_ext_req & core_active;
    blocked         = in_ext_req & ~out_ext_gnt;
    starve_cnt_inc  = starve_cnt + 1'b1;
    starve_cnt_next = '0;
    state_next      = IDLE;
    if (blocked) begin
      starve_cnt_next = (starve_cnt != LIMIT) ? starve_cnt_inc : starve_cnt;
      // Enter FORCE on the blocked cycle that brings the count up to the limit.
      if ((STARVE_LIMIT != 0) && (state == IDLE) && (starve_cnt_inc == LIMIT))
        state_next = FORCE;
    end
  end

  always_comb begin
    out_mem_rd_addr  = in_core_rd_addr;
    out_mem_wr_addr  = in_core_wr_addr;
    out_mem_wr_word  = in_core_wr_word;
    out_mem_write_en = reset & in_core_wr_en;
    if (out_ext_gnt) begin
      out_mem_rd_addr  = in_ext_addr;
      out_mem_wr_addr  = in_ext_addr;
      out_mem_wr_word  = in_ext_wdata;
      out_mem_write_en = in_ext_we;
    end
  end

  assign out_ext_rvalid = rvalid_q;
  assign out_ext_rdata  = in_mem_rd_word;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a limit-8 instance on a memory model and a limit-0
// instance sharing its inputs.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        core_rd_en, core_wr_en;
  logic [11:0] core_rd_addr, core_wr_addr;
  logic [15:0] core_wr_word;
  logic        ext_req, ext_we;
  logic [11:0] ext_addr;
  logic [15:0] ext_wdata;

  logic        core_stall, ext_gnt, ext_rvalid, mem_write_en;
  logic [15:0] ext_rdata, mem_rd_word, mem_wr_word;
  logic [11:0] mem_rd_addr, mem_wr_addr;

  logic        z_stall, z_gnt, z_rvalid, z_write_en;
  logic [15:0] z_rdata, z_wr_word, zero_word;
  logic [11:0] z_rd_addr, z_wr_addr;

  logic [15:0] mem_model [0:4095];

  int compare_count  = 0;
  int mismatch_count = 0;

  assign zero_word = 16'h0000;

  always #5 clock = ~clock;

  // Synchronous-read data memory standing in for dmem_sim.
  always @(posedge clock) begin
    if (mem_write_en) mem_model[mem_wr_addr] <= mem_wr_word;
    mem_rd_word <= mem_model[mem_rd_addr];
  end

  dmem_arbiter #(.DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .STARVE_LIMIT(8)) dut (
    .clock(clock), .reset(reset),
    .in_core_rd_en(core_rd_en), .in_core_wr_en(core_wr_en),
    .in_core_rd_addr(core_rd_addr), .in_core_wr_addr(core_wr_addr),
    .in_core_wr_word(core_wr_word), .out_core_stall(core_stall),
    .in_ext_req(ext_req), .in_ext_we(ext_we), .in_ext_addr(ext_addr),
    .in_ext_wdata(ext_wdata), .out_ext_gnt(ext_gnt), .out_ext_rvalid(ext_rvalid),
    .out_ext_rdata(ext_rdata), .in_mem_rd_word(mem_rd_word),
    .out_mem_rd_addr(mem_rd_addr), .out_mem_wr_addr(mem_wr_addr),
    .out_mem_wr_word(mem_wr_word), .out_mem_write_en(mem_write_en)
  );

  dmem_arbiter #(.DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .STARVE_LIMIT(0)) dut0 (
    .clock(clock), .reset(reset),
    .in_core_rd_en(core_rd_en), .in_core_wr_en(core_wr_en),
    .in_core_rd_addr(core_rd_addr), .in_core_wr_addr(core_wr_addr),
    .in_core_wr_word(core_wr_word), .out_core_stall(z_stall),
    .in_ext_req(ext_req), .in_ext_we(ext_we), .in_ext_addr(ext_addr),
    .in_ext_wdata(ext_wdata), .out_ext_gnt(z_gnt), .out_ext_rvalid(z_rvalid),
    .out_ext_rdata(z_rdata), .in_mem_rd_word(zero_word),
    .out_mem_rd_addr(z_rd_addr), .out_mem_wr_addr(z_wr_addr),
    .out_mem_wr_word(z_wr_word), .out_mem_write_en(z_write_en)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs just after the falling edge; checks follow 1 ns later.
  task automatic applyStimulus(input logic c_rd, input logic c_wr,
                               input logic [11:0] c_rd_addr, input logic [11:0] c_wr_addr,
                               input logic [15:0] c_wr_word, input logic e_req,
                               input logic e_we, input logic [11:0] e_addr,
                               input logic [15:0] e_wdata);
    @(negedge clock);
    core_rd_en   = c_rd;
    core_wr_en   = c_wr;
    core_rd_addr = c_rd_addr;
    core_wr_addr = c_wr_addr;
    core_wr_word = c_wr_word;
    ext_req      = e_req;
    ext_we       = e_we;
    ext_addr     = e_addr;
    ext_wdata    = e_wdata;
    #1;
  endtask

  initial begin
    // Reset behaviour: outputs forced low, memory addresses follow the core.
    applyStimulus(1'b0, 1'b1, 12'h0AA, 12'h0BB, 16'h1111, 1'b1, 1'b0, 12'h0CC, 16'h0);
    checkOutput("rst_gnt", 32'(ext_gnt), 32'd0);
    checkOutput("rst_stall", 32'(core_stall), 32'd0);
    checkOutput("rst_write_en", 32'(mem_write_en), 32'd0);
    checkOutput("rst_rvalid", 32'(ext_rvalid), 32'd0);
    checkOutput("rst_wr_addr", 32'(mem_wr_addr), 32'h0BB);
    checkOutput("rst_rd_addr", 32'(mem_rd_addr), 32'h0AA);
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    reset = 1'b1;

    // Idle core: external write then read back.
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b1, 1'b1, 12'h010, 16'hBEEF);
    checkOutput("idle_wr_gnt", 32'(ext_gnt), 32'd1);
    checkOutput("idle_wr_en", 32'(mem_write_en), 32'd1);
    checkOutput("idle_wr_addr", 32'(mem_wr_addr), 32'h010);
    checkOutput("idle_wr_word", 32'(mem_wr_word), 32'hBEEF);
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b1, 1'b0, 12'h010, 16'h0);
    checkOutput("idle_rd_gnt", 32'(ext_gnt), 32'd1);
    checkOutput("idle_rd_addr", 32'(mem_rd_addr), 32'h010);
    checkOutput("idle_rd_wen", 32'(mem_write_en), 32'd0);
    checkOutput("wr_no_rvalid", 32'(ext_rvalid), 32'd0);
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    checkOutput("idle_rvalid", 32'(ext_rvalid), 32'd1);
    checkOutput("idle_rdata", 32'(ext_rdata), 32'hBEEF);

    // Core priority: concurrent core store and external read of the same word.
    applyStimulus(1'b0, 1'b1, 12'h0, 12'h020, 16'h1234, 1'b1, 1'b0, 12'h020, 16'h0);
    checkOutput("prio_gnt", 32'(ext_gnt), 32'd0);
    checkOutput("prio_stall", 32'(core_stall), 32'd0);
    checkOutput("prio_wen", 32'(mem_write_en), 32'd1);
    checkOutput("prio_wr_addr", 32'(mem_wr_addr), 32'h020);
    checkOutput("prio_wr_word", 32'(mem_wr_word), 32'h1234);
    checkOutput("prio_rvalid", 32'(ext_rvalid), 32'd0);
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b1, 1'b0, 12'h020, 16'h0);
    checkOutput("prio_late_gnt", 32'(ext_gnt), 32'd1);
    checkOutput("prio_late_addr", 32'(mem_rd_addr), 32'h020);
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    checkOutput("prio_rvalid2", 32'(ext_rvalid), 32'd1);
    checkOutput("prio_rdata", 32'(ext_rdata), 32'h1234);

    // Starvation: core stores every cycle; the 9th request cycle is forced.
    for (int i = 1; i <= 9; i++) begin
      if (i < 9)
        applyStimulus(1'b0, 1'b1, 12'h0, 12'h030 + 12'(i), 16'h0100 + 16'(i),
                      1'b1, 1'b1, 12'h050, 16'hCAFE);
      else
        applyStimulus(1'b0, 1'b1, 12'h0, 12'h031, 16'h0BAD, 1'b1, 1'b1, 12'h050, 16'hCAFE);
      checkOutput($sformatf("starve_gnt_%0d", i), 32'(ext_gnt), 32'(i == 9));
      checkOutput($sformatf("starve_stall_%0d", i), 32'(core_stall), 32'(i == 9));
      checkOutput($sformatf("starve_wr_addr_%0d", i), 32'(mem_wr_addr),
                  (i == 9) ? 32'h050 : 32'h030 + 32'(i));
      checkOutput($sformatf("z_starve_gnt_%0d", i), 32'(z_gnt), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 12'h0, 12'h031, 16'h0BAD, 1'b0, 1'b0, 12'h0, 16'h0);
    checkOutput("stalled_not_written", 32'(mem_model[12'h031]), 32'h0101);
    checkOutput("forced_written", 32'(mem_model[12'h050]), 32'hCAFE);
    checkOutput("retry_gnt", 32'(ext_gnt), 32'd0);
    checkOutput("retry_stall", 32'(core_stall), 32'd0);
    checkOutput("retry_wen", 32'(mem_write_en), 32'd1);
    checkOutput("retry_wr_addr", 32'(mem_wr_addr), 32'h031);
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    checkOutput("retry_written", 32'(mem_model[12'h031]), 32'h0BAD);

    // 100 cycles of continuous core loads: forced grant every 9th cycle at limit 8,
    // never at limit 0.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b0, 12'h090, 12'h0, 16'h0, 1'b1, 1'b1, 12'h080, 16'h5555);
      checkOutput($sformatf("cont_gnt_%0d", i), 32'(ext_gnt), 32'((i % 9) == 8));
      checkOutput($sformatf("z_gnt_%0d", i), 32'(z_gnt), 32'd0);
      checkOutput($sformatf("z_stall_%0d", i), 32'(z_stall), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);

    // Reset in the cycle after a read grant.
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b1, 1'b0, 12'h010, 16'h0);
    checkOutput("rr_gnt", 32'(ext_gnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    checkOutput("rr_rvalid_pre", 32'(ext_rvalid), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("rr_rvalid_rst", 32'(ext_rvalid), 32'd0);
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    checkOutput("rr_rvalid_hold", 32'(ext_rvalid), 32'd0);
    reset = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b0, 1'b1, 12'h0, 12'h060, 16'h6666, 1'b1, 1'b1, 12'h070, 16'h7777);
      checkOutput($sformatf("post_rst_gnt_%0d", i), 32'(ext_gnt), 32'(i == 9));
      checkOutput($sformatf("post_rst_stall_%0d", i), 32'(core_stall), 32'(i == 9));
    end
    applyStimulus(1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single `dmem_sim` data memory between the core's memory stage and an external requester (debug/DMA port). The core normally has fixed priority. A starvation counter guarantees the external port is granted within `STARVE_LIMIT` blocked cycles by stalling the core for one cycle. Sits between the `mem` stage outputs and `dmem_sim`; `out_core_stall` feeds the pipeline freeze logic.

## Interface
- `DMEM_ADDR_WIDTH`, 12, data memory address width
- `DMEM_WORD_WIDTH`, 16, data memory word width
- `STARVE_LIMIT`, 8, blocked external cycles before a forced grant; 0 disables forcing
- `clock  in  1`  single clock, rising edge
- `reset  in  1`  asynchronous, active-low
- `in_core_rd_en  in  1`  core load this cycle
- `in_core_wr_en  in  1`  core store this cycle
- `in_core_rd_addr  in  DMEM_ADDR_WIDTH`  core read address
- `in_core_wr_addr  in  DMEM_ADDR_WIDTH`  core write address
- `in_core_wr_word  in  DMEM_WORD_WIDTH`  core write data
- `out_core_stall  out  1`  core access not performed; core must hold its request next cycle
- `in_ext_req  in  1`  external request valid
- `in_ext_we  in  1`  1 = write, 0 = read
- `in_ext_addr  in  DMEM_ADDR_WIDTH`  external address
- `in_ext_wdata  in  DMEM_WORD_WIDTH`  external write data
- `out_ext_gnt  out  1`  external transfer performed this cycle
- `out_ext_rvalid  out  1`  external read data valid
- `out_ext_rdata  out  DMEM_WORD_WIDTH`  external read data
- `in_mem_rd_word  in  DMEM_WORD_WIDTH`  `dmem_sim` read data (1-cycle synchronous read)
- `out_mem_rd_addr  out  DMEM_ADDR_WIDTH`  to `dmem_sim`
- `out_mem_wr_addr  out  DMEM_ADDR_WIDTH`  to `dmem_sim`
- `out_mem_wr_word  out  DMEM_WORD_WIDTH`  to `dmem_sim`
- `out_mem_write_en  out  1`  to `dmem_sim`

## Operation
- `core_active` = `in_core_rd_en | in_core_wr_en`.
- **States**
  - IDLE: normal core priority.
  - FORCE: one-cycle forced external grant.
- **Grant logic**
  - `out_ext_gnt` = `in_ext_req & (~core_active | state==FORCE)`.
  - `out_core_stall` = `state==FORCE & in_ext_req & core_active`.
- **Memory mux**
  - When `out_ext_gnt`=1: `out_mem_rd_addr` = `out_mem_wr_addr` = `in_ext_addr`; `out_mem_wr_word` = `in_ext_wdata`; `out_mem_write_en` = `in_ext_we`.
  - Otherwise: core addresses and data pass through; `out_mem_write_en` = `in_core_wr_en`.
- **Starvation counter**, width clog2(STARVE_LIMIT+1), saturating:
  - Increments on each cycle with `in_ext_req & ~out_ext_gnt`.
  - Clears on any cycle with `out_ext_gnt` or `~in_ext_req`.
  - IDLE→FORCE when the counter would reach `STARVE_LIMIT`, taking effect on the next edge.
  - FORCE→IDLE unconditionally after one cycle; the counter is 0 on exit.
  - `STARVE_LIMIT`=0: never enter FORCE.
- **External handshake**: the requester holds `in_ext_req`, `in_ext_we`, `in_ext_addr` and `in_ext_wdata` stable until it sees `out_ext_gnt`=1. The transfer happens in the grant cycle. A new request may be presented the very next cycle.
- **External read return**: a read granted at cycle N yields `out_ext_rvalid`=1 at N+1, with `out_ext_rdata` = `in_mem_rd_word` combinationally. The `rvalid` flag is registered.
- **Core stall**: a stalled core access performs no memory write; a stalled load's data is not the core's. The pipeline re-presents the access at N+1, where it wins because the state is back to IDLE.
- If `in_ext_req` drops while in FORCE (protocol violation): no grant, no stall, return to IDLE.

## Timing
- **Reset** (while `reset`=0): state IDLE, counter 0, `out_ext_rvalid` 0. `out_ext_gnt`, `out_core_stall` and `out_mem_write_en` are forced 0. Memory addresses and data follow the core inputs. Reset mid-transfer drops any pending `rvalid`.
- Grant, stall and memory mux are combinational, with zero latency.
- External read latency is exactly 1 cycle from grant.
- Worst-case external wait is `STARVE_LIMIT`+1 cycles from request to grant under continuous core traffic.
- External write and core read never occur in the same cycle; the arbiter is exclusive per cycle.

## Test plan
- **Idle core**: ext write addr 0x010 data 0xBEEF, then ext read 0x010. Required: `gnt` in the request cycle each time; `out_mem_write_en`=1 with `out_mem_wr_addr`=0x010 on the write; `rvalid`=1 with `rdata`=0xBEEF one cycle after the read grant.
- **Core priority**: core store to 0x020 concurrent with ext read 0x020. Required: `gnt`=0 and the core write is performed; with the core idle the next cycle, ext is granted and reads the new core value.
- **Starvation**: core active every cycle, ext req held, `STARVE_LIMIT`=8. Required: `gnt` and `out_core_stall` asserted in the 9th request cycle and only then; the core's stalled store is not written; the core retries and completes the next cycle.
- **STARVE_LIMIT=0** with core always active: `gnt` is never asserted over 100 cycles and `stall` stays 0.
- **Reset mid-read**: assert `reset` low in the cycle after an ext read grant. Required: `rvalid`=0 immediately; after release, state IDLE and counter 0, and a forced grant again takes 9 blocked cycles.
